spi_rx_fifo: RTL

SPI_RX_FIFO -- requirements
Module: spi_rx_fifo

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_rx_fifo_if.sv | 35 +++
 rtl/spi_rx_fifo_mem.sv | 37 +++
 rtl/spi_rx_fifo.sv | 104 ++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI constants and helpers for the receive FIFO
package spi_pkg;

    localparam int SPI_REG_WIDTH     = 8;
    localparam int SPI_RX_FIFO_DEPTH = 16;

    // Pointer width: one extra bit beyond the address so that full and
    // empty remain distinguishable when the pointers wrap.
    function automatic int fifo_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spi_rx_fifo_if.sv
// rtl/spi_rx_fifo_if.sv - write/read/status bundle of the SPI receive FIFO
//
// master: producer/consumer side (drives wr_*, clear, rd_ready)
// slave : FIFO side (drives rd_valid, rd_data, count, full, empty, overflow)
interface spi_rx_fifo_if
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_REG_WIDTH,
    parameter int DEPTH      = SPI_RX_FIFO_DEPTH
) ();

    localparam int PW = fifo_ptr_width(DEPTH);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  clear;
    logic                  rd_ready;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [PW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  overflow;

    modport master (
        output wr_en, wr_data, clear, rd_ready,
        input  rd_valid, rd_data, count, full, empty, overflow
    );

    modport slave (
        input  wr_en, wr_data, clear, rd_ready,
        output rd_valid, rd_data, count, full, empty, overflow
    );

endinterface

// File: rtl/spi_rx_fifo_mem.sv
// rtl/spi_rx_fifo_mem.sv - DEPTH x DATA_WIDTH storage, sync write, async read
//
// Ports:
//   clk      rising-edge clock for the write port
//   wr_en    store wr_data at wr_addr on the next edge
//   wr_addr  write address
//   wr_data  byte to store
//   rd_addr  read address
//   rd_data  contents at rd_addr (combinational)
module spi_rx_fifo_mem
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_REG_WIDTH,
    parameter int DEPTH      = SPI_RX_FIFO_DEPTH,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // No reset: occupancy is tracked by the pointers, so stale contents
    // are never presented as valid.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/spi_rx_fifo.sv
// rtl/spi_rx_fifo.sv - first-word fall-through receive FIFO for the SPI driver
//
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   wr_en       write strobe from the SPI driver
//   wr_data     received byte
//   clear       synchronous flush of contents and overflow flag
//   rd_ready    consumer accepts rd_data this cycle
//   rd_valid    rd_data holds the oldest entry
//   rd_data     oldest entry
//   count       occupancy, 0..DEPTH
//   full/empty  occupancy flags
//   overflow    sticky: a write was dropped while full
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_REG_WIDTH,
    parameter int DEPTH      = SPI_RX_FIFO_DEPTH
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            wr_en,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic                            clear,
    input  logic                            rd_ready,
    output logic                            rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [fifo_ptr_width(DEPTH)-1:0] count,
    output logic                            full,
    output logic                            empty,
    output logic                            overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = fifo_ptr_width(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          pop;
    logic          wr_accept;

    // Pointers carry a wrap bit, so their difference is the occupancy
    // directly, including the full case.
    assign count    = wr_ptr_q - rd_ptr_q;
    assign full     = (count == PW'(DEPTH));
    assign empty    = (count == '0);
    assign rd_valid = !empty;
    assign overflow = overflow_q;

    // A pop frees a slot in the same edge, so a write into a full FIFO
    // is still accepted when the consumer is reading.
    assign pop       = rd_valid && rd_ready && !clear;
    assign wr_accept = wr_en && !clear && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (wr_en && full && !pop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // On a write into a full FIFO with a pop, both addresses coincide;
    // the asynchronous read returns the old byte before the edge writes.
    spi_rx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (rd_data)
    );

endmodule
